// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles the instruction-memory handshake and the decode-side signals of the
//   fetch sequencer.
//   master : fetch sequencer side (drives Mem_Req/Inst_Addr and the decode outputs)
//   slave  : memory + decode side (drives Stall, redirect, Mem_Ready/Mem_Data)
//   Signals:
//     Stall, Branch_Taken, Branch_Target[63:0]  decode -> fetch
//     Mem_Req, Inst_Addr[63:0]                  fetch  -> memory
//     Mem_Ready, Mem_Data[31:0]                 memory -> fetch
//     Instruction[31:0], Inst_PC[63:0],
//     Inst_Valid, Fetch_Fault                   fetch  -> decode
interface fetch_sequencer_if;
    logic        Stall;
    logic        Branch_Taken;
    logic [63:0] Branch_Target;
    logic        Mem_Req;
    logic [63:0] Inst_Addr;
    logic        Mem_Ready;
    logic [31:0] Mem_Data;
    logic [31:0] Instruction;
    logic [63:0] Inst_PC;
    logic        Inst_Valid;
    logic        Fetch_Fault;

    modport master (
        input  Stall, Branch_Taken, Branch_Target, Mem_Ready, Mem_Data,
        output Mem_Req, Inst_Addr, Instruction, Inst_PC, Inst_Valid, Fetch_Fault
    );

    modport slave (
        output Stall, Branch_Taken, Branch_Target, Mem_Ready, Mem_Data,
        input  Mem_Req, Inst_Addr, Instruction, Inst_PC, Inst_Valid, Fetch_Fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the PC and fetches one 32-bit instruction at a time from byte-addressed
//   instruction memory, presenting it to decode. Handles decode stalls, branch
//   redirects, out-of-range PCs (PC >= MEM_LIMIT) and memory timeouts.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     bus    fetch_sequencer_if.master (memory handshake + decode outputs)
//   All outputs are registered except Mem_Req; Inst_Addr is the PC register.
//   Optional feature: define FETCH_ALIGN_CHECK_EN to fault on redirect targets with
//   Branch_Target[1:0] != 0. Without it, the low two target bits are forced to zero.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter logic [63:0] MEM_LIMIT = 64'd16,
    parameter int unsigned TIMEOUT   = 8
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StValid, StFault} state_e;

    state_e          state_q;
    logic [63:0]     pc_q;
    logic [31:0]     instruction_q;
    logic [63:0]     inst_pc_q;
    logic            inst_valid_q;
    logic            fetch_fault_q;
    logic [CntW-1:0] timeout_cnt_q;

    logic [63:0] redirect_pc;
    logic        redirect_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_pc         = bus.Branch_Target;
    assign redirect_misaligned = (bus.Branch_Target[1:0] != 2'b00);
`else
    assign redirect_pc         = bus.Branch_Target & ~64'h3;
    assign redirect_misaligned = 1'b0;
`endif

    // Branch_Taken suppresses the request so the old-path address never reaches memory.
    assign bus.Mem_Req     = (state_q == StFetch) && (pc_q < MEM_LIMIT) && !bus.Branch_Taken;
    assign bus.Inst_Addr   = pc_q;
    assign bus.Instruction = instruction_q;
    assign bus.Inst_PC     = inst_pc_q;
    assign bus.Inst_Valid  = inst_valid_q;
    assign bus.Fetch_Fault = fetch_fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instruction_q <= 32'd0;
            inst_pc_q     <= 64'd0;
            inst_valid_q  <= 1'b0;
            fetch_fault_q <= 1'b0;
            timeout_cnt_q <= '0;
        end else if (bus.Branch_Taken && (state_q != StIdle)) begin
            // A redirect wins in every active state; any presented instruction is wrong-path.
            pc_q          <= redirect_pc;
            inst_valid_q  <= 1'b0;
            timeout_cnt_q <= '0;
            fetch_fault_q <= redirect_misaligned;
            state_q       <= redirect_misaligned ? StFault : StFetch;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                end
                StFetch: begin
                    if (pc_q >= MEM_LIMIT) begin
                        fetch_fault_q <= 1'b1;
                        timeout_cnt_q <= '0;
                        state_q       <= StFault;
                    end else if (bus.Mem_Ready) begin
                        instruction_q <= bus.Mem_Data;
                        inst_pc_q     <= pc_q;
                        inst_valid_q  <= 1'b1;
                        pc_q          <= pc_q + 64'd4;
                        timeout_cnt_q <= '0;
                        state_q       <= StValid;
                    end else if (timeout_cnt_q == CntLast) begin
                        fetch_fault_q <= 1'b1;
                        timeout_cnt_q <= '0;
                        state_q       <= StFault;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 1'b1;
                    end
                end
                StValid: begin
                    if (!bus.Stall) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= StFetch;
                    end
                end
                StFault: begin
                    // Held until a redirect, handled above.
                    inst_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer with a four-word instruction memory model.
//   Honours FETCH_ALIGN_CHECK_EN for the misaligned-redirect step.
module tb_fetch_sequencer;

    logic clk;
    logic reset;
    logic mem_ready_en;
    int   errors;
    int   checks;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC (64'd0),
        .MEM_LIMIT(64'd16),
        .TIMEOUT  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [1:0] idx;
        idx = a[3:2];
        if (a >= 64'd16) return 32'd0;
        case (idx)
            2'd0:    return 32'h0F053483;
            2'd1:    return 32'h009A84B3;
            2'd2:    return 32'h00148493;
            default: return 32'h0E953823;
        endcase
    endfunction

    assign bus.Mem_Data  = mem_word(bus.Inst_Addr);
    assign bus.Mem_Ready = mem_ready_en;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] instr, input logic [63:0] pc);
        chk({tag, ".valid"}, {63'd0, bus.Inst_Valid}, 64'd1);
        chk({tag, ".instr"}, {32'd0, bus.Instruction}, {32'd0, instr});
        chk({tag, ".pc"}, bus.Inst_PC, pc);
    endtask

    task automatic redirect(input logic [63:0] target);
        bus.Branch_Taken  = 1'b1;
        bus.Branch_Target = target;
        tick();
        bus.Branch_Taken  = 1'b0;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        mem_ready_en = 1'b1;
        bus.Stall = 1'b0;
        bus.Branch_Taken = 1'b0;
        bus.Branch_Target = 64'd0;

        // Reset state
        tick();
        chk("rst.valid", {63'd0, bus.Inst_Valid}, 64'd0);
        chk("rst.fault", {63'd0, bus.Fetch_Fault}, 64'd0);
        chk("rst.instr", {32'd0, bus.Instruction}, 64'd0);
        chk("rst.ipc", bus.Inst_PC, 64'd0);
        chk("rst.addr", bus.Inst_Addr, 64'd0);
        chk("rst.req", {63'd0, bus.Mem_Req}, 64'd0);

        // Sequential fetch; idle cycle after release
        reset = 1'b1;
        #1;
        chk("idle.req", {63'd0, bus.Mem_Req}, 64'd0);
        tick();
        chk("f0.req", {63'd0, bus.Mem_Req}, 64'd1);
        chk("f0.addr", bus.Inst_Addr, 64'd0);
        tick();
        chk_inst("i0", 32'h0F053483, 64'd0);
        chk("i0.req", {63'd0, bus.Mem_Req}, 64'd0);
        tick();
        chk("f1.valid", {63'd0, bus.Inst_Valid}, 64'd0);
        chk("f1.addr", bus.Inst_Addr, 64'd4);
        tick();
        chk_inst("i1", 32'h009A84B3, 64'd4);

        // Stall holds the presented instruction for 5 cycles
        bus.Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_inst("stall", 32'h009A84B3, 64'd4);
            chk("stall.req", {63'd0, bus.Mem_Req}, 64'd0);
        end
        bus.Stall = 1'b0;
        tick();
        chk("f2.valid", {63'd0, bus.Inst_Valid}, 64'd0);
        chk("f2.addr", bus.Inst_Addr, 64'd8);
        tick();
        chk_inst("i2", 32'h00148493, 64'd8);

        // Redirect from S_VALID back to 0 drops the presented instruction
        redirect(64'd0);
        chk("br.valid", {63'd0, bus.Inst_Valid}, 64'd0);
        chk("br.addr", bus.Inst_Addr, 64'd0);
        chk("br.req", {63'd0, bus.Mem_Req}, 64'd1);
        tick();
        chk_inst("br.i0", 32'h0F053483, 64'd0);
        tick();
        tick();
        chk_inst("seq.i1", 32'h009A84B3, 64'd4);
        tick();
        tick();
        chk_inst("seq.i2", 32'h00148493, 64'd8);
        tick();
        tick();
        chk_inst("seq.i3", 32'h0E953823, 64'd12);

        // Walking off the end of memory faults without a request
        tick();
        chk("oor.req", {63'd0, bus.Mem_Req}, 64'd0);
        chk("oor.fault0", {63'd0, bus.Fetch_Fault}, 64'd0);
        tick();
        chk("oor.fault", {63'd0, bus.Fetch_Fault}, 64'd1);
        chk("oor.addr", bus.Inst_Addr, 64'h10);
        chk("oor.valid", {63'd0, bus.Inst_Valid}, 64'd0);
        tick();
        chk("oor.hold", {63'd0, bus.Fetch_Fault}, 64'd1);
        chk("oor.hreq", {63'd0, bus.Mem_Req}, 64'd0);

        // Timeout: Mem_Ready held low, fault 8 cycles after Mem_Req rises
        mem_ready_en = 1'b0;
        redirect(64'd0);
        chk("to.clr", {63'd0, bus.Fetch_Fault}, 64'd0);
        chk("to.req", {63'd0, bus.Mem_Req}, 64'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to.wait", {63'd0, bus.Fetch_Fault}, 64'd0);
        end
        tick();
        chk("to.fault", {63'd0, bus.Fetch_Fault}, 64'd1);
        chk("to.freq", {63'd0, bus.Mem_Req}, 64'd0);
        mem_ready_en = 1'b1;
        redirect(64'd4);
        chk("to.exit", {63'd0, bus.Fetch_Fault}, 64'd0);
        chk("to.addr", bus.Inst_Addr, 64'd4);
        tick();
        chk_inst("to.i1", 32'h009A84B3, 64'd4);

        // Reset pulsed while a request is live and memory is ready
        tick();
        chk("rp.req", {63'd0, bus.Mem_Req}, 64'd1);
        chk("rp.addr", bus.Inst_Addr, 64'd8);
        #2;
        reset = 1'b0;
        #1;
        chk("rp.req0", {63'd0, bus.Mem_Req}, 64'd0);
        chk("rp.addr0", bus.Inst_Addr, 64'd0);
        chk("rp.ipc0", bus.Inst_PC, 64'd0);
        chk("rp.instr0", {32'd0, bus.Instruction}, 64'd0);
        tick();
        chk("rp.valid", {63'd0, bus.Inst_Valid}, 64'd0);
        chk("rp.instr", {32'd0, bus.Instruction}, 64'd0);
        reset = 1'b1;
        tick();
        chk("rp.refetch", {63'd0, bus.Mem_Req}, 64'd1);
        chk("rp.raddr", bus.Inst_Addr, 64'd0);
        tick();
        chk_inst("rp.i0", 32'h0F053483, 64'd0);

        // Misaligned redirect to 0x6
        redirect(64'd6);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis.fault", {63'd0, bus.Fetch_Fault}, 64'd1);
        chk("mis.addr", bus.Inst_Addr, 64'd6);
        chk("mis.req", {63'd0, bus.Mem_Req}, 64'd0);
        redirect(64'd8);
        chk("mis.clr", {63'd0, bus.Fetch_Fault}, 64'd0);
        tick();
        chk_inst("mis.i2", 32'h00148493, 64'd8);
`else
        chk("mis.fault", {63'd0, bus.Fetch_Fault}, 64'd0);
        chk("mis.addr", bus.Inst_Addr, 64'd4);
        tick();
        chk_inst("mis.i1", 32'h009A84B3, 64'd4);
`endif

        // Redirect in S_FETCH beats a same-cycle Mem_Ready
        tick();
        bus.Branch_Taken  = 1'b1;
        bus.Branch_Target = 64'd12;
        #1;
        chk("bf.req", {63'd0, bus.Mem_Req}, 64'd0);
        tick();
        bus.Branch_Taken = 1'b0;
        #1;
        chk("bf.valid", {63'd0, bus.Inst_Valid}, 64'd0);
        chk("bf.addr", bus.Inst_Addr, 64'd12);
        tick();
        chk_inst("bf.i3", 32'h0E953823, 64'd12);

        // Redirect out of range faults on the following cycle
        redirect(64'h40);
        chk("bo.req", {63'd0, bus.Mem_Req}, 64'd0);
        chk("bo.valid", {63'd0, bus.Inst_Valid}, 64'd0);
        tick();
        chk("bo.fault", {63'd0, bus.Fetch_Fault}, 64'd1);
        chk("bo.addr", bus.Inst_Addr, 64'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
